// File: rtl/spu_instr_fetch.sv
// spu_instr_fetch: fetch-side consumer of the Program_Counter interface.
//
// Each cycle the current PC is turned into a pair-aligned read of the
// instruction local store. The returned instruction pair is tagged with its PC
// and written into a small prefetch queue. Decode pops the head with a
// valid/ready handshake. A taken branch (redirect) flushes the queue and
// squashes any read still in flight. Fetches from an odd branch target mark the
// even slot of the first pair as dead.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active low
//   pc_in           current PC from Program_Counter; bit PC_W-1 selects odd slot
//   redirect        taken branch, same signal that loads Program_Counter
//   pc_stall        hold Program_Counter; the queue cannot take another fetch
//   imem_rd_en      local-store read strobe
//   imem_addr       pair-aligned read address
//   imem_rdata      pair returned one cycle after imem_rd_en, even in [0:INSTR_W-1]
//   dec_valid       head entry valid
//   dec_ready       decode accepts the head entry
//   dec_instr_even  even instruction of the head pair
//   dec_instr_odd   odd instruction of the head pair
//   dec_slot_valid  [0] even slot live, [1] odd slot live
//   dec_pc          pair-aligned PC of the head pair
//
// Optional build macro FETCH_STATS_EN adds two saturating 16-bit counters:
//   stat_flush_cnt  cycles with redirect asserted
//   stat_stall_cnt  cycles with pc_stall asserted

module spu_instr_fetch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:PC_W-1]      pc_in,
  input  logic                 redirect,
  output logic                 pc_stall,
  output logic                 imem_rd_en,
  output logic [0:PC_W-1]      imem_addr,
  input  logic [0:2*INSTR_W-1] imem_rdata,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [0:INSTR_W-1]   dec_instr_even,
  output logic [0:INSTR_W-1]   dec_instr_odd,
  output logic [0:1]           dec_slot_valid,
  output logic [0:PC_W-1]      dec_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [0:15]          stat_flush_cnt,
  output logic [0:15]          stat_stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 2 * INSTR_W;

  // Ascending port vectors are copied into descending locals so that numeric
  // bit 0 is the odd-select bit and the upper half of the data is the even slot.
  logic [PC_W-1:0] pc_num;
  logic [DW-1:0]   rdata_num;

  assign pc_num    = pc_in;
  assign rdata_num = imem_rdata;

  // Queue storage, not reset: outputs are gated by dec_valid.
  logic [PC_W-1:0] mem_pc_q   [DEPTH];
  logic [DW-1:0]   mem_data_q [DEPTH];
  logic [1:0]      mem_slot_q [DEPTH];

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] tag_pc_q, tag_pc_d;
  logic            odd_start_q, odd_start_d;

  logic            pop_req;
  logic            pop;
  logic            push;
  logic            full;
  logic [CW:0]     occ;
  logic [CW:0]     limit;
  logic [PC_W-1:0] pair_pc;

  assign pair_pc = {pc_num[PC_W-1:1], 1'b0};

  // Handshake and queue events. A redirect flushes everything, so neither a
  // pop nor the return of the in-flight read has any effect in that cycle.
  assign dec_valid = (count_q != '0);
  assign pop_req   = dec_valid && dec_ready;
  assign pop       = pop_req && !redirect;
  assign push      = inflight_q && !redirect;

  // Another fetch fits only if an entry is still free after counting the read
  // in flight; a pop in the same cycle frees one, so a full queue drained at
  // the decode rate keeps fetching every cycle.
  assign occ   = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign limit = (CW + 1)'(DEPTH) + (CW + 1)'(pop_req);
  assign full  = (occ >= limit);

  // Stall is released during a redirect so Program_Counter loads the target.
  assign pc_stall   = rst && !redirect && full;
  assign imem_rd_en = rst && !pc_stall && !redirect;
  assign imem_addr  = rst ? pair_pc : '0;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = imem_rd_en;
    tag_pc_d    = tag_pc_q;
    odd_start_d = odd_start_q;

    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (imem_rd_en) begin
      tag_pc_d    = pair_pc;
      odd_start_d = pc_num[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      odd_start_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      tag_pc_q    <= tag_pc_d;
      odd_start_q <= odd_start_d;
    end
  end

  // A pair fetched from an odd target carries a dead even slot.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_pc_q[wr_ptr_q]   <= tag_pc_q;
      mem_data_q[wr_ptr_q] <= rdata_num;
      mem_slot_q[wr_ptr_q] <= odd_start_q ? 2'b01 : 2'b11;
    end
  end

  always_comb begin
    dec_pc         = '0;
    dec_instr_even = '0;
    dec_instr_odd  = '0;
    dec_slot_valid = '0;
    if (dec_valid) begin
      dec_pc         = mem_pc_q[rd_ptr_q];
      dec_instr_even = mem_data_q[rd_ptr_q][DW-1:INSTR_W];
      dec_instr_odd  = mem_data_q[rd_ptr_q][INSTR_W-1:0];
      dec_slot_valid = mem_slot_q[rd_ptr_q];
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] flush_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign stat_flush_cnt = flush_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // The stall logic must never let a return land in a full queue without a pop.
  overflow_a : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_spu_instr_fetch.sv
module tb_spu_instr_fetch;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pc_in;
  logic        redirect;
  logic        pc_stall;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr_even;
  logic [31:0] dec_instr_odd;
  logic [1:0]  dec_slot_valid;
  logic [9:0]  dec_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_flush_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  spu_instr_fetch #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .redirect      (redirect),
    .pc_stall      (pc_stall),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr_even(dec_instr_even),
    .dec_instr_odd (dec_instr_odd),
    .dec_slot_valid(dec_slot_valid),
    .dec_pc        (dec_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_flush_cnt(stat_flush_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // Reference model: an ordered list of fetched pairs plus the one read the
  // local store still owes us.
  typedef struct {
    logic [9:0]  pc;
    logic [63:0] data;
    logic [1:0]  slot;
  } ent_t;

  ent_t        q[$];
  bit          pend;
  logic [9:0]  pend_pc;
  logic [63:0] pend_data;
  logic [9:0]  pc_cur;
  int unsigned m_flush;
  int unsigned m_stall;
  bit          chk_en;
  int          n_chk;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic cyc(input bit r, input bit rdy, input bit redir, input logic [9:0] tgt);
    bit         e_valid;
    bit         e_stall;
    bit         e_rden;
    bit         e_pop;
    logic [9:0] e_addr;
    ent_t       e;

    rst        = r;
    dec_ready  = rdy;
    redirect   = redir;
    pc_in      = pc_cur;
    imem_rdata = pend ? pend_data : {$urandom, $urandom};

    @(negedge clk);
    e_valid = (q.size() > 0);
    e_pop   = e_valid && rdy;
    e_stall = r && !redir && ((q.size() + int'(pend)) >= (DEPTH + int'(e_pop)));
    e_rden  = r && !e_stall && !redir;
    e_addr  = r ? {pc_cur[9:1], 1'b0} : 10'h000;

    if (chk_en) begin
      check("pc_stall", 64'(pc_stall), 64'(e_stall));
      check("imem_rd_en", 64'(imem_rd_en), 64'(e_rden));
      check("imem_addr", 64'(imem_addr), 64'(e_addr));
      check("dec_valid", 64'(dec_valid), 64'(e_valid));
      check("dec_pc", 64'(dec_pc), e_valid ? 64'(q[0].pc) : 64'd0);
      check("dec_instr_even", 64'(dec_instr_even), e_valid ? 64'(q[0].data[63:32]) : 64'd0);
      check("dec_instr_odd", 64'(dec_instr_odd), e_valid ? 64'(q[0].data[31:0]) : 64'd0);
      check("dec_slot_valid", 64'(dec_slot_valid), e_valid ? 64'(q[0].slot) : 64'd0);
`ifdef FETCH_STATS_EN
      check("stat_flush_cnt", 64'(stat_flush_cnt), 64'(m_flush));
      check("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stall));
`endif
    end

    if (!r || redir) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (pend) begin
        e.pc   = {pend_pc[9:1], 1'b0};
        e.data = pend_data;
        e.slot = pend_pc[0] ? 2'b01 : 2'b11;
        q.push_back(e);
      end
      pend = e_rden;
      if (e_rden) begin
        pend_pc   = pc_cur;
        pend_data = {$urandom, $urandom};
      end
    end

    if (!r) begin
      m_flush = 0;
      m_stall = 0;
    end else begin
      if (redir && m_flush < 65535) m_flush++;
      if (e_stall && m_stall < 65535) m_stall++;
    end

    if (!r) pc_cur = 10'h000;
    else if (redir) pc_cur = tgt;
    else if (!e_stall) pc_cur = pc_cur + 10'd2;

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    redirect   = 1'b0;
    dec_ready  = 1'b0;
    pc_in      = '0;
    imem_rdata = '0;
    pend       = 1'b0;
    pend_pc    = '0;
    pend_data  = '0;
    pc_cur     = '0;
    m_flush    = 0;
    m_stall    = 0;
    chk_en     = 1'b0;
    n_chk      = 0;
    n_fail     = 0;
    #1;

    // Reset: first cycle applies it, second checks the cleared state.
    cyc(1'b0, 1'b0, 1'b0, 10'h000);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 10'h000);

    // Sequential fetch from PC 0 with decode always ready.
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Backpressure until stalled, one pop, then hold again.
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 10'h000);
    cyc(1'b1, 1'b1, 1'b0, 10'h000);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 10'h000);

    // Redirect to an odd target with three entries queued and one in flight.
    cyc(1'b1, 1'b0, 1'b1, 10'h0F0);
    for (int i = 0; i < 20 && !(q.size() == 3 && pend); i++) cyc(1'b1, 1'b0, 1'b0, 10'h000);
    cyc(1'b1, 1'b0, 1'b1, 10'h105);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Full queue, redirect and dec_ready in the same cycle.
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 10'h000);
    cyc(1'b1, 1'b1, 1'b1, 10'h200);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Back-to-back redirects; only the last target fetches.
    cyc(1'b1, 1'b1, 1'b1, 10'h011);
    cyc(1'b1, 1'b1, 1'b1, 10'h033);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Odd target just below the top of the PC space: addresses wrap to 0.
    cyc(1'b1, 1'b1, 1'b1, 10'h3FB);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Reset mid-stream with a read in flight, then resume.
    cyc(1'b1, 1'b0, 1'b0, 10'h000);
    cyc(1'b0, 1'b1, 1'b0, 10'h000);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 10'h000);

    // Randomized traffic.
    repeat (400) begin
      cyc(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 10'($urandom));
    end

`ifdef FETCH_STATS_EN
    // Three redirects and a run of stalls, then drive the stall counter to saturation.
    cyc(1'b0, 1'b0, 1'b0, 10'h000);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 10'h040);
    repeat (9) cyc(1'b1, 1'b0, 1'b0, 10'h000);
    repeat (70000) cyc(1'b1, 1'b0, 1'b0, 10'h000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
